// File: rtl/maze_player_controller.sv
// Player controller for the maze renderer: synchronises the four buttons, auto-repeats held
// ones and moves the player tile through open cells, counting moves and flagging the finish.
module maze_player_controller #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [255:0] path_data,
  input  logic [4:0]   maze_width,
  input  logic [4:0]   maze_height,
  input  logic [4:0]   start_x,
  input  logic [4:0]   start_y,
  input  logic [4:0]   finish_x,
  input  logic [4:0]   finish_y,
  output logic [6:0]   char_x,
  output logic [6:0]   char_y,
  output logic [15:0]  move_count,
  output logic         bump,
  output logic         won
);

  localparam int CW = $clog2(REPEAT_DELAY) + 1;

  typedef enum logic [1:0] {IDLE, PLAY, WON} state_t;

  // Button vectors are ordered {up, down, left, right}, i.e. by descending priority.
  logic [3:0] raw;
  logic [3:0] sync1_reg, sync2_reg, prev_reg;
  logic [3:0] sel;
  logic       any, rise, expire, req;

  logic [CW-1:0] rpt_cnt_reg;
  logic          armed_reg;

  state_t      state_reg, state_next;
  logic [3:0]  cx_reg, cx_next, cy_reg, cy_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        bump_reg, bump_next;

  logic [4:0] tx, ty;
  logic       blocked, legal, at_finish;
  logic       unused_bits;

  assign raw = {btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_comb begin
    sel = 4'b0000;
    if (sync2_reg[3])      sel = 4'b1000;
    else if (sync2_reg[2]) sel = 4'b0100;
    else if (sync2_reg[1]) sel = 4'b0010;
    else if (sync2_reg[0]) sel = 4'b0001;
  end

  assign any    = |sync2_reg;
  assign rise   = |(sel & ~prev_reg);
  assign expire = armed_reg && any && !rise && (rpt_cnt_reg == CW'(REPEAT_DELAY - 1));
  assign req    = rise || expire;

  // Repeats are only armed by a genuine press edge, so a button held through reset or load
  // never starts moving on its own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else if (load || !any) begin
      rpt_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else if (rise) begin
      rpt_cnt_reg <= '0;
      armed_reg   <= 1'b1;
    end else if (armed_reg) begin
      if (expire) rpt_cnt_reg <= CW'(REPEAT_DELAY - REPEAT_PERIOD);
      else        rpt_cnt_reg <= rpt_cnt_reg + CW'(1);
    end
  end

  always_comb begin
    tx      = {1'b0, cx_reg};
    ty      = {1'b0, cy_reg};
    blocked = 1'b0;
    if (sel[3]) begin
      blocked = (cy_reg == 4'd0);
      ty      = {1'b0, cy_reg} - 5'd1;
    end else if (sel[2]) begin
      ty      = {1'b0, cy_reg} + 5'd1;
    end else if (sel[1]) begin
      blocked = (cx_reg == 4'd0);
      tx      = {1'b0, cx_reg} - 5'd1;
    end else begin
      tx      = {1'b0, cx_reg} + 5'd1;
    end
  end

  assign legal     = !blocked && (tx < maze_width) && (ty < maze_height) &&
                     path_data[{ty[3:0], tx[3:0]}];
  assign at_finish = ({1'b0, cx_reg} == finish_x) && ({1'b0, cy_reg} == finish_y);

  always_comb begin
    state_next = state_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    cnt_next   = cnt_reg;
    bump_next  = 1'b0;
    case (state_reg)
      PLAY: begin
        if (at_finish) begin
          state_next = WON;
        end else if (req) begin
          if (legal) begin
            cx_next = tx[3:0];
            cy_next = ty[3:0];
            if (cnt_reg != 16'hFFFF) cnt_next = cnt_reg + 16'd1;
          end else begin
            bump_next = 1'b1;
          end
        end
      end
      IDLE, WON: ;
      default: state_next = IDLE;
    endcase
    if (load) begin
      state_next = PLAY;
      cx_next    = start_x[3:0];
      cy_next    = start_y[3:0];
      cnt_next   = 16'd0;
      bump_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cx_reg    <= 4'd0;
      cy_reg    <= 4'd0;
      cnt_reg   <= 16'd0;
      bump_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      cnt_reg   <= cnt_next;
      bump_reg  <= bump_next;
    end
  end

  // Mazes are at most 16 tiles, so the top coordinate bit of the start tile is never stored.
  assign unused_bits = &{1'b0, start_x[4], start_y[4]};

  assign char_x     = {3'b000, cx_reg};
  assign char_y     = {3'b000, cy_reg};
  assign move_count = cnt_reg;
  assign bump       = bump_reg;
  assign won        = (state_reg == WON);

endmodule

// File: tb/tb_maze_player_controller.sv
// Bench for maze_player_controller: directed scenarios with literal expectations plus random
// button traffic, all checked every cycle against a tile-level behavioural model.
module tb_maze_player_controller;

  localparam int RD = 8;
  localparam int RP = 3;
  localparam int M_IDLE = 0, M_PLAY = 1, M_WON = 2;
  localparam logic [3:0] B_U = 4'b1000, B_D = 4'b0100, B_L = 4'b0010, B_R = 4'b0001;

  logic         clk = 1'b0, reset = 1'b0, load = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [255:0] path_data = '0;
  logic [4:0]   maze_width = 5'd4, maze_height = 5'd4;
  logic [4:0]   start_x = '0, start_y = '0, finish_x = 5'd3, finish_y = 5'd3;
  logic [6:0]   char_x, char_y;
  logic [15:0]  move_count;
  logic         bump, won;

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: tile position, counters and a raw-sample history of the buttons.
  int         m_x = 0, m_y = 0, m_cnt = 0, m_mode = M_IDLE, m_held = 0;
  bit         m_bump = 1'b0, m_armed = 1'b0;
  logic [3:0] hist [3];

  maze_player_controller #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .load(load),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
    .start_x(start_x), .start_y(start_y), .finish_x(finish_x), .finish_y(finish_y),
    .char_x(char_x), .char_y(char_y), .move_count(move_count), .bump(bump), .won(won)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] s, p;
    int  d, dx, dy, nx, ny;
    bit  rise, rep, req, legal;
    if (!reset) begin
      m_x = 0; m_y = 0; m_cnt = 0; m_mode = M_IDLE; m_bump = 1'b0;
      m_armed = 1'b0; m_held = 0;
      for (int i = 0; i < 3; i++) hist[i] = 4'b0;
      return;
    end
    // A raw sample taken at edge n is acted on at edge n+2; p is one edge older.
    s = hist[1];
    p = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {btn_up, btn_down, btn_left, btn_right};
    d = -1;
    for (int i = 0; i < 4; i++) if (s[i]) d = i;
    rise = (d >= 0) && !p[d];
    rep  = 1'b0;
    if (load || d < 0) begin
      m_armed = 1'b0;
    end else if (rise) begin
      m_armed = 1'b1;
      m_held  = 0;
    end else if (m_armed) begin
      m_held++;
      rep = (m_held >= RD) && ((m_held - RD) % RP == 0);
    end
    req = rise || rep;
    m_bump = 1'b0;
    if (load) begin
      m_mode = M_PLAY; m_x = int'(start_x); m_y = int'(start_y); m_cnt = 0;
    end else if (m_mode == M_PLAY) begin
      if (m_x == int'(finish_x) && m_y == int'(finish_y)) begin
        m_mode = M_WON;
      end else if (req) begin
        dx = (d == 0) ? 1 : (d == 1) ? -1 : 0;
        dy = (d == 2) ? 1 : (d == 3) ? -1 : 0;
        nx = m_x + dx;
        ny = m_y + dy;
        legal = nx >= 0 && ny >= 0 && nx < int'(maze_width) && ny < int'(maze_height) &&
                path_data[nx + 16 * ny];
        if (legal) begin
          m_x = nx; m_y = ny;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_bump = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      tests++;
      if (char_x !== 7'(m_x) || char_y !== 7'(m_y) || move_count !== 16'(m_cnt) ||
          bump !== m_bump || won !== (m_mode == M_WON)) begin
        fails++;
        $display("FAIL cycle_model t=%0t: got x=%0d y=%0d cnt=%0d bump=%b won=%b, expected x=%0d y=%0d cnt=%0d bump=%b won=%b",
                 $time, char_x, char_y, move_count, bump, won,
                 m_x, m_y, m_cnt, m_bump, m_mode == M_WON);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic press(logic [3:0] m, int hold, int gap);
    set_btn(m);
    tick(hold);
    set_btn(4'b0);
    tick(gap);
  endtask

  initial begin
    int w, h;
    logic [3:0] m;
    // 4x4 maze: row 0 and column 3 open, (1,1) closed.
    path_data = '0;
    for (int i = 0; i < 4; i++) path_data[i] = 1'b1;
    for (int j = 1; j < 4; j++) path_data[3 + 16 * j] = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    check("reset_char_x", 32'(char_x), 0);
    check("reset_char_y", 32'(char_y), 0);
    check("reset_count", 32'(move_count), 0);
    check("reset_won", 32'(won), 0);
    #2 reset = 1'b1;
    tick(1);

    press(B_R, 3, 4);
    check("idle_ignores_x", 32'(char_x), 0);
    check("idle_ignores_cnt", 32'(move_count), 0);
    pulse_load();
    check("load_x", 32'(char_x), 0);
    check("load_cnt", 32'(move_count), 0);
    check("load_won", 32'(won), 0);

    set_btn(B_R);
    tick(2);
    check("latency_before", 32'(char_x), 0);
    tick(1);
    check("latency_after", 32'(char_x), 1);
    set_btn(4'b0);
    tick(3);
    press(B_R, 3, 3);
    check("right2_x", 32'(char_x), 2);
    press(B_R, 3, 3);
    check("right3_x", 32'(char_x), 3);
    check("right3_cnt", 32'(move_count), 3);

    set_btn(B_R);
    tick(3);
    check("edge_bump", 32'(bump), 1);
    check("edge_stay_x", 32'(char_x), 3);
    tick(1);
    check("bump_one_cycle", 32'(bump), 0);
    set_btn(4'b0);
    tick(3);

    pulse_load();
    set_btn(B_U);
    tick(3);
    check("underflow_bump", 32'(bump), 1);
    check("underflow_y", 32'(char_y), 0);
    set_btn(4'b0);
    tick(3);
    press(B_R, 3, 3);
    set_btn(B_D);
    tick(3);
    check("wall_bump", 32'(bump), 1);
    check("wall_cnt", 32'(move_count), 1);
    set_btn(4'b0);
    tick(3);
    set_btn(B_U | B_R);
    tick(3);
    check("priority_bump", 32'(bump), 1);
    check("priority_x", 32'(char_x), 1);
    set_btn(4'b0);
    tick(3);

    press(B_R, 3, 3);
    press(B_R, 3, 3);
    press(B_D, 3, 3);
    press(B_D, 3, 3);
    set_btn(B_D);
    tick(3);
    check("arrive_y", 32'(char_y), 3);
    check("arrive_not_won", 32'(won), 0);
    tick(1);
    check("won_next", 32'(won), 1);
    set_btn(4'b0);
    tick(3);
    press(B_L, 3, 3);
    check("won_ignores_x", 32'(char_x), 3);
    check("won_cnt", 32'(move_count), 6);

    set_btn(B_R);
    tick(2);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("load_vs_edge_x", 32'(char_x), 0);
    check("load_vs_edge_cnt", 32'(move_count), 0);
    check("load_vs_edge_won", 32'(won), 0);
    tick(12);
    check("no_repeat_after_load", 32'(char_x), 0);
    set_btn(4'b0);
    tick(3);

    set_btn(B_R);
    tick(4);
    #2 reset = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    tick(3);
    pulse_load();
    tick(14);
    check("held_through_reset", 32'(char_x), 0);
    set_btn(4'b0);
    tick(3);
    press(B_R, 3, 3);
    check("fresh_edge_after_reset", 32'(char_x), 1);

    // Auto-repeat on an open 16-wide row.
    path_data = '1;
    maze_width = 5'd16; maze_height = 5'd1;
    finish_x = 5'd15; finish_y = 5'd15;
    pulse_load();
    press(B_R, 20, 4);
    check("repeat_moves", 32'(char_x), 5);
    check("repeat_cnt", 32'(move_count), 5);

    for (int it = 0; it < 120; it++) begin
      if (it % 20 == 0) begin
        w = $urandom_range(1, 16);
        h = $urandom_range(1, 16);
        maze_width  = 5'(w);
        maze_height = 5'(h);
        for (int k = 0; k < 8; k++) path_data[32 * k +: 32] = $urandom;
        start_x  = 5'($urandom_range(0, w - 1));
        start_y  = 5'($urandom_range(0, h - 1));
        finish_x = 5'($urandom_range(0, w - 1));
        finish_y = 5'($urandom_range(0, h - 1));
        path_data[int'(start_x) + 16 * int'(start_y)] = 1'b1;
        pulse_load();
      end
      if ($urandom_range(0, 3) == 0) m = 4'($urandom);
      else m = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 14) == 0) pulse_load();
      if ($urandom_range(0, 9) == 0) path_data[$urandom_range(0, 255)] ^= 1'b1;
      press(m, $urandom_range(1, 30), $urandom_range(0, 5));
    end

    // Saturation: alternate right/left every cycle on a 2-wide row, one legal move per cycle.
    path_data = '1;
    maze_width = 5'd2; maze_height = 5'd1;
    start_x = 5'd0; start_y = 5'd0; finish_x = 5'd0; finish_y = 5'd1;
    tick(4);
    pulse_load();
    for (int i = 0; i < 65545; i++) begin
      set_btn((i % 2 == 0) ? B_R : B_L);
      tick(1);
    end
    set_btn(4'b0);
    tick(4);
    check("saturated_cnt", 32'(move_count), 32'h0000FFFF);
    check("saturated_bump", 32'(bump), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_player_controller.md
# maze_player_controller

Turns the four direction buttons into the player's tile position (`char_x`, `char_y`) that the maze renderer draws. It sits directly upstream of the renderer and consumes the same maze description: `path_data`, maze size, start and finish tiles. It synchronises and edge-detects the buttons, auto-repeats held buttons, rejects moves into walls or off the maze, counts accepted moves and flags arrival at the finish tile.

## Interface
- `REPEAT_DELAY`, default 25_000_000: cycles a button must be held before the first auto-repeat.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeats.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  one-cycle pulse; (re)start play at the start tile.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, active-high buttons.
- `path_data`  in  256  bit `x + 16*y` = 1 means tile (x,y) is open.
- `maze_width`, `maze_height`  in  5 each  maze size in tiles, 1..16.
- `start_x`, `start_y`, `finish_x`, `finish_y`  in  5 each  tile coordinates.
- `char_x`, `char_y`  out  7 each  player tile; bits [6:4] are always 0.
- `move_count`  out  16  accepted moves since last `load`; saturates at 16'hFFFF.
- `bump`  out  1  one-cycle pulse on a rejected move attempt.
- `won`  out  1  high while in state WON.

## Operation
- **Button path**
  - Each button passes through a 2-flop synchroniser. Stage-2 outputs are s_u, s_d, s_l, s_r; p_* holds the previous stage-2 value.
  - Priority: up > down > left > right. Only the highest-priority pressed button is considered; the others are ignored while it is held.
  - A move request (req) is raised when:
    - the selected button has a rising edge (s=1, p=0), or
    - the repeat counter expires.
- **Repeat counter**
  - Clears on any rising edge or when no button is pressed.
  - Counts while the selected button is held.
  - First expiry is at REPEAT_DELAY cycles after the edge, then every REPEAT_PERIOD cycles.
- **States: IDLE, PLAY, WON**
  - IDLE (after reset): ignore requests.
  - Any state + `load`: char ← (start_x, start_y); move_count ← 0; bump ← 0; go to PLAY. `load` has priority over a same-cycle request.
  - PLAY + char == finish: go to WON. Checked on registered position, so entry is one cycle after arrival. If start == finish, WON is entered one cycle after entering PLAY.
  - PLAY + req, and char != finish: compute target tx, ty as 5-bit values.
    - up: ty = y−1; down: ty = y+1; left: tx = x−1; right: tx = x+1.
    - The move is legal iff:
      - no underflow (y ≠ 0 for up, x ≠ 0 for left), and
      - tx < maze_width and ty < maze_height, and
      - path_data[tx + 16*ty] = 1.
    - Legal: update char; move_count += 1, saturating.
    - Illegal: char unchanged; bump = 1 for one cycle.
  - WON: ignore requests; only `load` or reset leaves.
- **Inputs:** `path_data` and the size, start and finish inputs are sampled live every cycle and not latched.

## Timing
- **Reset (asynchronous assert):** state = IDLE; char_x = char_y = 0; move_count = 0; bump = 0; won = 0; synchronisers, p_* and repeat counter = 0.
- **Load latency:** a `load` sampled at edge k makes char = start and state = PLAY visible after edge k. `won` rises after edge k+1 at the earliest.
- **Button latency:** a button first sampled high at edge k gives:
  - s = 1 after edge k+1;
  - position/count/bump update at edge k+2.
  - Three edges total, inclusive.
- **Holding a button:**
  - Exactly one move at the edge.
  - Repeats at edge + REPEAT_DELAY, then every REPEAT_PERIOD cycles.
  - Release and re-press: a new edge gives an immediate move and restarts the delay.
- **Simultaneous buttons:** at most one move per cycle.
- **Reset mid-hold:** after reset, a still-held button produces no move until `load` then a fresh rising edge. p_* resumes from the synchroniser, so a held button gives no phantom edge after `load`.
- **Bump:** high exactly one cycle per rejected request; never high in IDLE or WON.

## Test plan
- **Reset and load:** reset low, then high; `load` with start (0,0) -> char (0,0), move_count 0, won 0; before `load`, a right press -> no change.
- **Open moves:** 4×4 maze, path_data row 0 all open, start (0,0), finish (3,3). Press right 3 times -> char_x 1, 2, 3; move_count 3. Each update lands on the third edge after press.
- **Walls and edges:**
  - At (3,0), right -> tx = 4 ≥ width: bump, no move.
  - At (0,0), up -> underflow: bump.
  - Down into a closed tile (1,1) -> bump; move_count unchanged.
- **Auto-repeat:** REPEAT_DELAY = 8, REPEAT_PERIOD = 3; hold right on an open 16-wide row for 20 cycles -> moves at edge, +8, +11, +14, +17 (5 moves).
- **Priority:** up and right pressed together -> only up attempted.
- **Win and restart:**
  - Reach (3,3) -> won = 1 one cycle later; further presses are ignored.
  - `load` the same cycle as a button edge -> char = start, move_count 0, won 0, no move.
  - move_count forced to 16'hFFFF saturates on the next legal move.
